// File: rtl/bpm_tx_link_arbiter.sv
// bpm_tx_link_arbiter
// Shares one Aurora BPM TX AXI stream among N_SRC packet sources.
// Round-robin arbitration happens per packet, and a grant is held until its
// tlast beat. Traffic is gated by auroraChannelUp. A packet that stalls, or
// that is cut by a channel drop, is drained to its tlast and dropped.
// One status strobe is issued per packet end, and the number of good packets
// is latched on every FA cycle strobe.
module bpm_tx_link_arbiter #(
   parameter int N_SRC      = 2,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255,
   localparam int GW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                        auroraUserClk,
   input  logic                        auroraUserRst_n,
   input  logic                        auroraChannelUp,
   input  logic                        auroraFAstrobe,
   input  logic [N_SRC*DATA_WIDTH-1:0] s_tdata,
   input  logic [N_SRC-1:0]            s_tvalid,
   input  logic [N_SRC-1:0]            s_tlast,
   output logic [N_SRC-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]       m_tdata,
   output logic                        m_tvalid,
   output logic                        m_tlast,
   input  logic                        m_tready,
   output logic [GW-1:0]               grantIndex,
   output logic                        statusStrobe,
   output logic [1:0]                  statusCode,
   output logic [15:0]                 faPacketCount
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [1:0]  CODE_SENT    = 2'd0;
   localparam logic [1:0]  CODE_CHAN    = 2'd1;
   localparam logic [1:0]  CODE_TIMEOUT = 2'd2;
   localparam logic [1:0]  CODE_FA      = 2'd3;
   localparam logic [15:0] IDLE_LIMIT   = 16'(TIMEOUT - 1);

   state_e                  state_q, state_d;
   logic [GW-1:0]           grant_q, grant_d;
   logic [GW-1:0]           rr_q, rr_d;
   logic [15:0]             idle_q, idle_d;
   logic [15:0]             ok_q, ok_d;
   logic [15:0]             fa_q, fa_d;
   logic [1:0]              pend_q, pend_d;
   logic                    strobe_q, strobe_d;
   logic [1:0]              code_q, code_d;

   logic [N_SRC-1:0]        grant_oh_s;
   logic [DATA_WIDTH-1:0]   sel_data_s;
   logic                    sel_valid_s;
   logic                    sel_last_s;
   logic                    beat_s;
   logic [GW-1:0]           next_ptr_s;
   logic                    ev_valid_s;
   logic [1:0]              ev_code_s;
   logic                    done_s;
   logic                    fa_mid_s;
   logic [2:0]              pend_sum_s;
   logic [15:0]             ok_inc_s;

   // First requester at or after ptr, wrapping cyclically.
   function automatic logic [GW-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                             input logic [GW-1:0]    ptr);
      logic [GW-1:0] hi_sel;
      logic [GW-1:0] lo_sel;
      logic          hi_found;
      hi_sel   = '0;
      lo_sel   = '0;
      hi_found = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         lo_sel   = req[i] ? GW'(i) : lo_sel;
         hi_sel   = (req[i] && (GW'(i) >= ptr)) ? GW'(i) : hi_sel;
         hi_found = hi_found | (req[i] && (GW'(i) >= ptr));
      end
      return hi_found ? hi_sel : lo_sel;
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   // Multiplex the granted source onto internal select signals.
   always_comb begin
      grant_oh_s  = '0;
      sel_data_s  = '0;
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
         grant_oh_s[i] = (grant_q == GW'(i));
         sel_data_s    = sel_data_s | ((grant_q == GW'(i)) ? s_tdata[i*DATA_WIDTH +: DATA_WIDTH]
                                                           : {DATA_WIDTH{1'b0}});
         sel_valid_s   = sel_valid_s | ((grant_q == GW'(i)) & s_tvalid[i]);
         sel_last_s    = sel_last_s  | ((grant_q == GW'(i)) & s_tlast[i]);
      end
   end

   // Drive the stream outputs and the per-source ready from the current state.
   always_comb begin
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tlast  = 1'b0;
      s_tready = '0;
      case (state_q)
         ST_PASS: begin
            m_tvalid = sel_valid_s & auroraChannelUp;
            m_tdata  = sel_data_s;
            m_tlast  = sel_last_s;
            s_tready = grant_oh_s & {N_SRC{m_tready & auroraChannelUp}};
         end
         ST_DRAIN: begin
            s_tready = grant_oh_s;
         end
         default: begin
            s_tready = '0;
         end
      endcase
   end

   assign beat_s     = m_tvalid & m_tready;
   assign next_ptr_s = (grant_q == GW'(N_SRC - 1)) ? '0 : grant_q + GW'(1);

   // Next-state logic: arbitration, forwarding, timeout and abort events.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      idle_d     = idle_q;
      ev_valid_s = 1'b0;
      ev_code_s  = CODE_SENT;
      done_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (auroraChannelUp && (|s_tvalid)) begin
               grant_d = rr_pick(s_tvalid, rr_q);
               state_d = ST_PASS;
               idle_d  = 16'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PASS: begin
            if (!auroraChannelUp) begin
               // Channel lost: nothing forwarded this cycle, drain the rest.
               state_d    = ST_DRAIN;
               ev_valid_s = 1'b1;
               ev_code_s  = CODE_CHAN;
            end else if (beat_s && sel_last_s) begin
               state_d    = ST_IDLE;
               rr_d       = next_ptr_s;
               ev_valid_s = 1'b1;
               ev_code_s  = CODE_SENT;
               done_s     = 1'b1;
               idle_d     = 16'd0;
            end else if (beat_s) begin
               idle_d = 16'd0;
            end else if (!sel_valid_s) begin
               if (idle_q >= IDLE_LIMIT) begin
                  state_d    = ST_DRAIN;
                  ev_valid_s = 1'b1;
                  ev_code_s  = CODE_TIMEOUT;
               end else begin
                  idle_d = idle_q + 16'd1;
               end
            end else begin
               // Source valid but sink back-pressuring: not a source stall.
               idle_d = idle_q;
            end
         end
         ST_DRAIN: begin
            if (sel_valid_s && sel_last_s) begin
               state_d = ST_IDLE;
               rr_d    = next_ptr_s;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Status strobe scheduling and per-FA-cycle packet accounting.
   always_comb begin
      fa_mid_s   = auroraFAstrobe & (state_q != ST_IDLE);
      pend_sum_s = {1'b0, pend_q} + {2'b00, fa_mid_s};
      ok_inc_s   = sat_inc(ok_q, done_s);
      if (auroraFAstrobe) begin
         fa_d = ok_inc_s;
         ok_d = 16'd0;
      end else begin
         fa_d = fa_q;
         ok_d = ok_inc_s;
      end
      if (ev_valid_s) begin
         // A packet-end strobe wins the slot; FA overrun waits its turn.
         strobe_d = 1'b1;
         code_d   = ev_code_s;
         pend_d   = (pend_sum_s > 3'd3) ? 2'd3 : pend_sum_s[1:0];
      end else if (pend_sum_s != 3'd0) begin
         strobe_d = 1'b1;
         code_d   = CODE_FA;
         pend_d   = 2'(pend_sum_s - 3'd1);
      end else begin
         strobe_d = 1'b0;
         code_d   = CODE_SENT;
         pend_d   = 2'd0;
      end
   end

   // FSM state, grant, round-robin pointer and stall counter registers.
   always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
      if (!auroraUserRst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         rr_q    <= '0;
         idle_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         idle_q  <= idle_d;
      end
   end

   // Status and packet-count registers.
   always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
      if (!auroraUserRst_n) begin
         ok_q     <= 16'd0;
         fa_q     <= 16'd0;
         pend_q   <= 2'd0;
         strobe_q <= 1'b0;
         code_q   <= 2'd0;
      end else begin
         ok_q     <= ok_d;
         fa_q     <= fa_d;
         pend_q   <= pend_d;
         strobe_q <= strobe_d;
         code_q   <= code_d;
      end
   end

   assign grantIndex    = grant_q;
   assign statusStrobe  = strobe_q;
   assign statusCode    = code_q;
   assign faPacketCount = fa_q;

endmodule

// File: tb/tb_bpm_tx_link_arbiter.sv
// Bench for bpm_tx_link_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a packet-level model.
module tb_bpm_tx_link_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          auroraUserRst_n = 1'b0;
   logic          auroraChannelUp = 1'b1;
   logic          auroraFAstrobe = 1'b0;
   logic [31:0]   sdat [0:2];
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]  s_tvalid = '0;
   logic [N-1:0]  s_tlast = '0;
   logic [N-1:0]  s_tready;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b1;
   logic [1:0]    grantIndex;
   logic          statusStrobe;
   logic [1:0]    statusCode;
   logic [15:0]   faPacketCount;

   int n_checks = 0;
   int n_fail = 0;

   // model state: ms 0=waiting for grant, 1=forwarding, 2=discarding
   int         ms = 0;
   logic [1:0] mg = 2'd0;
   logic [1:0] mrr = 2'd0;
   int         midle = 0;
   int         mok = 0;
   int         mfa = 0;
   int         mpend = 0;
   logic       mstrb = 1'b0;
   logic [1:0] mcode = 2'd0;

   assign s_tdata = {sdat[2], sdat[1], sdat[0]};

   bpm_tx_link_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .auroraUserClk  (clk),
      .auroraUserRst_n(auroraUserRst_n),
      .auroraChannelUp(auroraChannelUp),
      .auroraFAstrobe (auroraFAstrobe),
      .s_tdata        (s_tdata),
      .s_tvalid       (s_tvalid),
      .s_tlast        (s_tlast),
      .s_tready       (s_tready),
      .m_tdata        (m_tdata),
      .m_tvalid       (m_tvalid),
      .m_tlast        (m_tlast),
      .m_tready       (m_tready),
      .grantIndex     (grantIndex),
      .statusStrobe   (statusStrobe),
      .statusCode     (statusCode),
      .faPacketCount  (faPacketCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance the packet-level model by one clock edge.
   task automatic model_step();
      int   ev;
      int   done;
      bit   busy;
      logic v;
      logic l;
      logic [1:0] c;
      bit   found;
      if (!auroraUserRst_n) begin
         ms = 0; mg = 2'd0; mrr = 2'd0; midle = 0; mok = 0; mfa = 0;
         mpend = 0; mstrb = 1'b0; mcode = 2'd0;
         return;
      end
      ev = -1;
      done = 0;
      busy = (ms != 0);
      v = s_tvalid[mg];
      l = s_tlast[mg];
      if (ms == 0) begin
         if (auroraChannelUp && s_tvalid != 3'b000) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               c = 2'((int'(mrr) + k) % N);
               if (!found && s_tvalid[c]) begin
                  mg = c;
                  found = 1'b1;
               end
            end
            ms = 1;
            midle = 0;
         end
      end else if (ms == 1) begin
         if (!auroraChannelUp) begin
            ev = 1; ms = 2;
         end else if (v && m_tready) begin
            midle = 0;
            if (l) begin
               ev = 0; done = 1; ms = 0;
               mrr = 2'((int'(mg) + 1) % N);
            end
         end else if (!v) begin
            midle++;
            if (midle >= TO) begin
               ev = 2; ms = 2;
            end
         end
      end else begin
         if (v && l) begin
            ms = 0;
            mrr = 2'((int'(mg) + 1) % N);
         end
      end
      if (auroraFAstrobe) begin
         if (busy) mpend++;
         mfa = (mok + done > 65535) ? 65535 : mok + done;
         mok = 0;
      end else begin
         mok = (mok + done > 65535) ? 65535 : mok + done;
      end
      if (ev >= 0) begin
         mstrb = 1'b1; mcode = 2'(ev);
      end else if (mpend > 0) begin
         mstrb = 1'b1; mcode = 2'd3; mpend--;
      end else begin
         mstrb = 1'b0; mcode = 2'd0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge auroraUserRst_n);
         model_step();
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      logic [2:0]  one;
      logic        e_tv;
      logic        e_tl;
      logic [31:0] e_td;
      logic [2:0]  e_tr;
      one = 3'b001;
      forever begin
         @(negedge clk);
         e_tv = (ms == 1) ? (s_tvalid[mg] & auroraChannelUp) : 1'b0;
         e_td = (ms == 1) ? sdat[mg] : 32'd0;
         e_tl = (ms == 1) ? s_tlast[mg] : 1'b0;
         e_tr = (ms == 1) ? ((m_tready && auroraChannelUp) ? (one << mg) : 3'b000)
              : (ms == 2) ? (one << mg) : 3'b000;
         chk("m_tvalid", m_tvalid, e_tv);
         chk("m_tdata", m_tdata, e_td);
         chk("m_tlast", m_tlast, e_tl);
         chk("s_tready", s_tready, e_tr);
         chk("grantIndex", grantIndex, mg);
         chk("statusStrobe", statusStrobe, mstrb);
         chk("statusCode", statusCode, mcode);
         chk("faPacketCount", faPacketCount, 16'(mfa));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc;
      int         strobes;
      int         rem [0:2];
      int         stall [0:2];
      int         cudown;
      logic [2:0] hs;
      for (int i = 0; i < N; i++) sdat[i] = 32'd0;

      // Reset state
      #23 auroraUserRst_n = 1'b1;
      @(negedge clk);
      chk("rst_m_tvalid", m_tvalid, 1'b0);
      chk("rst_grant", grantIndex, 2'd0);
      chk("rst_strobe", statusStrobe, 1'b0);
      chk("rst_facount", faPacketCount, 16'd0);

      // 4-beat packet from source 0, one cycle of arbitration latency
      tick();
      s_tvalid = 3'b001; sdat[0] = 32'hA0; s_tlast = 3'b000;
      @(negedge clk);
      chk("arb_latency", m_tvalid, 1'b0);
      for (int b = 0; b < 4; b++) begin
         tick();
         sdat[0] = 32'hA0 + 32'(b);
         s_tlast = (b == 3) ? 3'b001 : 3'b000;
         @(negedge clk);
         chk("p1_valid", m_tvalid, 1'b1);
         chk("p1_data", m_tdata, 32'hA0 + 32'(b));
         chk("p1_grant", grantIndex, 2'd0);
      end
      tick();
      s_tvalid = 3'b000; s_tlast = 3'b000;
      @(negedge clk);
      chk("p1_strobe", statusStrobe, 1'b1);
      chk("p1_code", statusCode, 2'd0);
      tick(); auroraFAstrobe = 1'b1;
      tick(); auroraFAstrobe = 1'b0;
      @(negedge clk);
      chk("fa_count_1", faPacketCount, 16'd1);

      // Source 1 stalls after its first beat -> timeout abort, then drain
      tick();
      s_tvalid = 3'b010; sdat[1] = 32'hB0; s_tlast = 3'b000;
      tick();
      tick();
      s_tvalid = 3'b000;
      cyc = 0;
      @(negedge clk);
      while (!statusStrobe && cyc < 20) begin
         tick();
         cyc++;
         @(negedge clk);
      end
      chk("timeout_cycles", cyc, 8);
      chk("timeout_code", statusCode, 2'd2);
      chk("drain_ready", s_tready, 3'b010);
      chk("drain_no_valid", m_tvalid, 1'b0);
      tick();
      s_tvalid = 3'b010; s_tlast = 3'b010; sdat[1] = 32'hB1;
      tick();
      s_tvalid = 3'b000; s_tlast = 3'b000;

      // Long back-pressure never times out
      tick();
      m_tready = 1'b0;
      s_tvalid = 3'b001; sdat[0] = 32'hD0; s_tlast = 3'b001;
      strobes = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         @(negedge clk);
         if (statusStrobe) strobes++;
      end
      chk("bp_no_strobe", strobes, 0);
      chk("bp_hold_valid", m_tvalid, 1'b1);
      chk("bp_grant", grantIndex, 2'd0);
      tick();
      m_tready = 1'b1;
      tick();
      s_tvalid = 3'b000; s_tlast = 3'b000;
      @(negedge clk);
      chk("bp_strobe", statusStrobe, 1'b1);
      chk("bp_code", statusCode, 2'd0);
      tick(); auroraFAstrobe = 1'b1;
      tick(); auroraFAstrobe = 1'b0;
      @(negedge clk);
      chk("fa_count_2", faPacketCount, 16'd1);

      // Reset in the middle of a packet from source 2
      tick();
      s_tvalid = 3'b100; sdat[2] = 32'hC0; s_tlast = 3'b000;
      tick();
      @(negedge clk);
      chk("rst_mid_valid", m_tvalid, 1'b1);
      chk("rst_mid_grant", grantIndex, 2'd2);
      #2 auroraUserRst_n = 1'b0;
      #1;
      chk("async_m_tvalid", m_tvalid, 1'b0);
      chk("async_s_tready", s_tready, 3'b000);
      chk("async_grant", grantIndex, 2'd0);
      chk("async_facount", faPacketCount, 16'd0);
      s_tvalid = 3'b000;
      @(negedge clk);
      #2 auroraUserRst_n = 1'b1;

      // Randomized traffic
      cudown = 0;
      for (int i = 0; i < N; i++) begin
         rem[i] = $urandom_range(1, 5);
         stall[i] = 0;
         sdat[i] = $urandom;
         s_tlast[i] = (rem[i] == 1);
      end
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         hs = s_tvalid & s_tready;
         tick();
         for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
               rem[i]--;
               if (rem[i] == 0) rem[i] = $urandom_range(1, 5);
               sdat[i] = $urandom;
               s_tlast[i] = (rem[i] == 1);
            end
            if (stall[i] > 0) begin
               stall[i]--;
               s_tvalid[i] = 1'b0;
            end else begin
               s_tvalid[i] = ($urandom_range(0, 3) != 0);
               if ($urandom_range(0, 30) == 0) stall[i] = $urandom_range(4, 12);
            end
         end
         m_tready = ($urandom_range(0, 3) != 0);
         auroraFAstrobe = ($urandom_range(0, 39) == 0);
         if (cudown > 0) begin
            cudown--;
            auroraChannelUp = 1'b0;
         end else begin
            auroraChannelUp = 1'b1;
            if ($urandom_range(0, 79) == 0) cudown = $urandom_range(1, 4);
         end
      end
      tick();
      auroraFAstrobe = 1'b0;
      auroraChannelUp = 1'b1;
      s_tvalid = 3'b000;
      repeat (3) tick();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
